vending_machine_mp: RTL
=======================

Name: vending_machine_mp

Overview:
- Parametrised multi-product vending controller. Accepts one-hot coins into a credit register, vends a selected product when credit covers its price, and tracks per-product stock.
- Returns change or refunds credit as a sequence of single-coin pulses, one per cycle, using greedy 5/2/1 denominations.
- Sits between the coin acceptor and the dispenser/payout mechanics. Supersedes the fixed single-price, change-as-a-number controller.

Parameters:
- NUM_PRODUCTS, 4, number of products; product index width is IDW = clog2(NUM_PRODUCTS), minimum 1.
- CREDIT_W, 8, width of the credit, price and change arithmetic.
- MAX_CREDIT, 50, maximum credit accepted; a coin that would exceed it is rejected.
- PRICE_LIST, {8'd15,8'd12,8'd10,8'd7}, packed prices; product i at bits [CREDIT_W*i +: CREDIT_W]. Default gives p0=7, p1=10, p2=12, p3=15.
- STOCK_W, 4, width of each stock counter.
- STOCK_INIT, 4, stock loaded into every product at reset and on restock.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset; 0 clears all state.
- coin, input, 4, one-hot single-cycle coin strobe: 0001=1, 0010=2, 0100=5, 1000=10.
- sel_valid, input, 1, purchase request strobe.
- sel_id, input, IDW, product requested; sampled when sel_valid=1.
- cancel, input, 1, refund all credit.
- restock, input, 1, reload every stock counter to STOCK_INIT.
- product_valid, output, 1, one-cycle dispense pulse.
- product_id, output, IDW, product dispensed; valid while product_valid=1.
- change_valid, output, 1, one-cycle payout pulse, one coin per pulse.
- change_coin, output, 3, one-hot payout coin: 001=1, 010=2, 100=5.
- coin_reject, output, 1, one-cycle pulse; the offending coin is returned and not credited.
- err_funds, output, 1, one-cycle pulse; selection refused for insufficient credit.
- err_soldout, output, 1, one-cycle pulse; selection refused because stock is 0.
- busy, output, 1, high in the CHANGE state.
- credit, output, CREDIT_W, current credit (registered).
- sold_out, output, NUM_PRODUCTS, bit i = 1 when stock[i] = 0.

Behaviour:
- Outputs: all registered.
- Reset values: all outputs 0, credit=0, state IDLE. Every stock counter = STOCK_INIT, so sold_out=0.
- Reset mid-operation: reset during CHANGE aborts the payout; the remaining change is lost by design.
- States: IDLE and CHANGE. Vend is a single IDLE-cycle action, not a separate state.
- IDLE priority, highest first: cancel > sel_valid > coin > restock.
- IDLE, cancel=1:
  - credit>0: load remain=credit, set credit=0, go to CHANGE.
  - credit=0: no action.
- IDLE, sel_valid=1 (s = sel_id):
  - s >= NUM_PRODUCTS or stock[s]=0: err_soldout=1 next cycle.
  - otherwise credit < price[s]: err_funds=1 next cycle.
  - otherwise, next cycle: product_valid=1, product_id=s, stock[s] decremented, credit=0, remain = credit - price[s]. Go to CHANGE if remain>0, else stay in IDLE.
  - Latency from sel_valid to product_valid is 1 cycle.
- IDLE, coin:
  - Nonzero and not one-hot, or credit+value > MAX_CREDIT: coin_reject=1 next cycle, credit unchanged.
  - Otherwise: credit += value next cycle.
  - credit = MAX_CREDIT exactly is legal.
- Losing the priority in the same IDLE cycle:
  - A coin arriving together with cancel or sel_valid is rejected (coin_reject pulse).
  - restock arriving together with cancel, sel_valid or a coin is ignored.
- restock alone in IDLE: all stock counters = STOCK_INIT next cycle.
- CHANGE, each cycle:
  - change_valid=1 with the largest coin <= remain (5, then 2, then 1); remain decremented by that coin.
  - When remain reaches 0, return to IDLE in the same cycle as the last pulse.
  - Pulses are back-to-back; payout of remain=R takes floor(R/5) + greedy-remainder pulses.
- CHANGE, inputs: every nonzero coin gets coin_reject; sel_valid, cancel and restock are ignored. busy=1 throughout.
- Arithmetic: all in CREDIT_W bits, unsigned. Credit can never exceed MAX_CREDIT, so no wrap.
- Stock counters: saturate at 0; never decremented below 0.
- sold_out: updated in the same cycle as its stock counter.

Test Plan:
- Coins 5,5 then sel 0 (price 7) -> credit 10; product_valid, id 0 one cycle after select; then change_valid coin 2, then coin 1 on consecutive cycles; busy high for 2 cycles; credit 0.
- Coins 5,2,1 then cancel -> change pulses 5, 2, 1 on three consecutive cycles; no product_valid; credit 0.
- Credit 8, sel 2 (price 12) -> err_funds pulse; credit stays 8; no dispense.
- Four exact-price purchases of product 1 (10 each) -> sold_out[1]=1. Fifth select of product 1 -> err_soldout. restock -> sold_out=0.
- Credit 45, insert 10 -> coin_reject, credit 45. Insert 5 -> credit 50. Coin 0011 -> coin_reject.
- Credit 20, sel 0 -> remain 13. Assert reset after the first 5-coin pulse -> all outputs 0, credit 0, stock reloaded, state IDLE.

Source files
------------

// File: rtl/vending_machine_mp.sv
// rtl/vending_machine_mp.sv - multi-product vending controller with greedy 5/2/1 coin payout
module vending_machine_mp #(
  parameter int NUM_PRODUCTS = 4,
  parameter int CREDIT_W     = 8,
  parameter int MAX_CREDIT   = 50,
  parameter logic [CREDIT_W*NUM_PRODUCTS-1:0] PRICE_LIST = {8'd15, 8'd12, 8'd10, 8'd7},
  parameter int STOCK_W      = 4,
  parameter int STOCK_INIT   = 4,
  localparam int IDW = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              coin,
  input  logic                    sel_valid,
  input  logic [IDW-1:0]          sel_id,
  input  logic                    cancel,
  input  logic                    restock,
  output logic                    product_valid,
  output logic [IDW-1:0]          product_id,
  output logic                    change_valid,
  output logic [2:0]              change_coin,
  output logic                    coin_reject,
  output logic                    err_funds,
  output logic                    err_soldout,
  output logic                    busy,
  output logic [CREDIT_W-1:0]     credit,
  output logic [NUM_PRODUCTS-1:0] sold_out
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_CHANGE = 1'b1;

  logic [0:0]          r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] r_remain;
  logic [STOCK_W-1:0]  r_stock [NUM_PRODUCTS];
  logic                r_product_valid;
  logic [IDW-1:0]      r_product_id;
  logic                r_change_valid;
  logic [2:0]          r_change_coin;
  logic                r_coin_reject;
  logic                r_err_funds;
  logic                r_err_soldout;

  logic [CREDIT_W-1:0] w_price_tab [NUM_PRODUCTS];
  logic [CREDIT_W-1:0] w_coin_val;
  logic [CREDIT_W:0]   w_credit_sum;
  logic                w_coin_any;
  logic                w_coin_ok;
  logic                w_sel_in_range;
  logic [STOCK_W-1:0]  w_sel_stock;
  logic [CREDIT_W-1:0] w_sel_price;
  logic [2:0]          w_pay_coin;
  logic [CREDIT_W-1:0] w_pay_val;

  genvar g;
  generate
    for (g = 0; g < NUM_PRODUCTS; g++) begin : g_prod
      assign w_price_tab[g] = PRICE_LIST[CREDIT_W*g +: CREDIT_W];
      assign sold_out[g]    = (r_stock[g] == '0);
    end
  endgenerate

  // Any pattern other than a single set bit decodes to zero and is rejected.
  always_comb begin
    w_coin_val = '0;
    case (coin)
      4'b0001: w_coin_val = CREDIT_W'(1);
      4'b0010: w_coin_val = CREDIT_W'(2);
      4'b0100: w_coin_val = CREDIT_W'(5);
      4'b1000: w_coin_val = CREDIT_W'(10);
      default: w_coin_val = '0;
    endcase
  end

  assign w_coin_any     = |coin;
  assign w_credit_sum   = {1'b0, r_credit} + {1'b0, w_coin_val};
  assign w_coin_ok      = (w_coin_val != '0) && (w_credit_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign w_sel_in_range = (32'(sel_id) < NUM_PRODUCTS);
  assign w_sel_stock    = w_sel_in_range ? r_stock[sel_id] : '0;
  assign w_sel_price    = w_sel_in_range ? w_price_tab[sel_id] : '0;

  always_comb begin
    w_pay_coin = 3'b001;
    w_pay_val  = CREDIT_W'(1);
    if (r_remain >= CREDIT_W'(5)) begin
      w_pay_coin = 3'b100;
      w_pay_val  = CREDIT_W'(5);
    end else if (r_remain >= CREDIT_W'(2)) begin
      w_pay_coin = 3'b010;
      w_pay_val  = CREDIT_W'(2);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_credit        <= '0;
      r_remain        <= '0;
      r_product_valid <= 1'b0;
      r_product_id    <= '0;
      r_change_valid  <= 1'b0;
      r_change_coin   <= '0;
      r_coin_reject   <= 1'b0;
      r_err_funds     <= 1'b0;
      r_err_soldout   <= 1'b0;
      for (int i = 0; i < NUM_PRODUCTS; i++) r_stock[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      r_product_valid <= 1'b0;
      r_product_id    <= '0;
      r_change_valid  <= 1'b0;
      r_change_coin   <= '0;
      r_coin_reject   <= 1'b0;
      r_err_funds     <= 1'b0;
      r_err_soldout   <= 1'b0;
      if (r_state == S_IDLE) begin
        if (cancel) begin
          r_coin_reject <= w_coin_any;
          if (r_credit != '0) begin
            r_remain <= r_credit;
            r_credit <= '0;
            r_state  <= S_CHANGE;
          end
        end else if (sel_valid) begin
          r_coin_reject <= w_coin_any;
          if (!w_sel_in_range || (w_sel_stock == '0)) begin
            r_err_soldout <= 1'b1;
          end else if (r_credit < w_sel_price) begin
            r_err_funds <= 1'b1;
          end else begin
            r_product_valid  <= 1'b1;
            r_product_id     <= sel_id;
            r_stock[sel_id]  <= w_sel_stock - STOCK_W'(1);
            r_credit         <= '0;
            r_remain         <= r_credit - w_sel_price;
            if (r_credit != w_sel_price) r_state <= S_CHANGE;
          end
        end else if (w_coin_any) begin
          if (w_coin_ok) r_credit <= w_credit_sum[CREDIT_W-1:0];
          else           r_coin_reject <= 1'b1;
        end else if (restock) begin
          for (int i = 0; i < NUM_PRODUCTS; i++) r_stock[i] <= STOCK_W'(STOCK_INIT);
        end
      end else begin
        // Leave CHANGE on the same edge that emits the final coin.
        r_change_valid <= 1'b1;
        r_change_coin  <= w_pay_coin;
        r_remain       <= r_remain - w_pay_val;
        r_coin_reject  <= w_coin_any;
        if (r_remain == w_pay_val) r_state <= S_IDLE;
      end
    end
  end

  assign product_valid = r_product_valid;
  assign product_id    = r_product_id;
  assign change_valid  = r_change_valid;
  assign change_coin   = r_change_coin;
  assign coin_reject   = r_coin_reject;
  assign err_funds     = r_err_funds;
  assign err_soldout   = r_err_soldout;
  assign busy          = (r_state == S_CHANGE);
  assign credit        = r_credit;

endmodule
